// File: rtl/key_debounce_if.sv
// Key bus between the board pins and the pattern-control logic.
// slave: the debouncer (takes raw pins, drives clean levels/pulses); master: the consumer side.
interface key_debounce_if #(
  parameter int KEY_W = 4
);
  logic [KEY_W-1:0] key_n;
  logic [KEY_W-1:0] key_level;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_release;
  logic [KEY_W-1:0] key_long;

  modport master (output key_n, input key_level, key_press, key_release, key_long);
  modport slave  (input key_n, output key_level, key_press, key_release, key_long);
endinterface

// File: rtl/key_debounce.sv
// Per-key synchronizer + debounce/long-press FSM, one lane instance per key.
// Optional auto-repeat of key_press while held past LONG_CYC: define KEY_REPEAT_EN.
module key_debounce_lane #(
  parameter int unsigned DEBOUNCE_CYC = 1,
  parameter int unsigned LONG_CYC     = 1
`ifdef KEY_REPEAT_EN
  , parameter int unsigned REPEAT_CYC = 1
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRESS_DB, ST_PRESSED, ST_LONG, ST_RELEASE_DB
  } state_e;

  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYC - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);

  logic [1:0]  sync_q;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        long_flag_q, long_flag_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        s;

  // Synchronizer resets to "released" so nothing fires on reset exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key_n_i};
  end

  assign s = ~sync_q[1];

`ifdef KEY_REPEAT_EN
  localparam logic [31:0] REP_LAST = 32'(REPEAT_CYC - 1);
  logic [31:0] rep_q, rep_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_flag_d = long_flag_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d       = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_DB;
          cnt_d   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d     = ST_LONG;
          long_d      = 1'b1;
          long_flag_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_LONG: begin
        if (!s) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (rep_q == REP_LAST) begin
          press_d = 1'b1;
        end else begin
          rep_d = rep_q + 32'd1;
        end
`endif
      end
      ST_RELEASE_DB: begin
        // A bounce back to pressed resumes the hold phase with a fresh timer.
        if (s) begin
          state_d = long_flag_q ? ST_LONG : ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = ST_IDLE;
          release_d   = 1'b1;
          level_d     = 1'b0;
          long_flag_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
endmodule

module key_debounce #(
  parameter int          KEY_W        = 4,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 10_000_000
) (
  input logic         clk,
  input logic         rst_n,
  key_debounce_if.slave kif
);
  if (DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1) begin : g_param_chk
    $error("key_debounce: cycle parameters must be >= 1");
  end

  logic [KEY_W-1:0] level, press, rel, lng;

  for (genvar g = 0; g < KEY_W; g++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
`ifdef KEY_REPEAT_EN
      , .REPEAT_CYC (REPEAT_CYC)
`endif
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_i   (kif.key_n[g]),
      .level_o   (level[g]),
      .press_o   (press[g]),
      .release_o (rel[g]),
      .long_o    (lng[g])
    );
  end

  assign kif.key_level   = level;
  assign kif.key_press   = press;
  assign kif.key_release = rel;
  assign kif.key_long    = lng;
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios with literal timing plus a random phase,
// all cross-checked every cycle against a run-length/anchor-time model of the key rules.
module tb_key_debounce;
  localparam int KW = 4;
  localparam int D  = 4;
  localparam int LC = 10;
  localparam int RC = 3;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  key_debounce_if #(.KEY_W(KW)) kif();

  key_debounce #(
    .KEY_W(KW), .DEBOUNCE_CYC(D), .LONG_CYC(LC), .REPEAT_CYC(RC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Model: s is the pin delayed two edges; edges are accepted after D+1 equal samples;
  // hold/repeat timers are measured from anchor edges (acceptance or bounce-back).
  logic [KW-1:0] sy1, sy2, m_lvl, m_press, m_rel, m_long;
  int  t;
  int  rl [KW];
  bit  sv [KW];
  bit  lvl [KW];
  bit  ldone [KW];
  int  anc [KW];
  int  ranc [KW];

  task automatic model_reset();
    sy1 = '1; sy2 = '1; t = 0;
    m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
    for (int k = 0; k < KW; k++) begin
      rl[k] = 0; sv[k] = 1'b0; lvl[k] = 1'b0; ldone[k] = 1'b0; anc[k] = 0; ranc[k] = 0;
    end
  endtask

  task automatic model_step();
    bit s;
    t++;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int k = 0; k < KW; k++) begin
      s = ~sy2[k];
      if (rl[k] > 0 && s == sv[k]) rl[k]++;
      else begin sv[k] = s; rl[k] = 1; end
      if (!lvl[k]) begin
        if (s && rl[k] == D + 1) begin
          m_press[k] = 1'b1; lvl[k] = 1'b1; anc[k] = t;
        end
      end else if (!s) begin
        if (rl[k] == D + 1) begin
          m_rel[k] = 1'b1; lvl[k] = 1'b0; ldone[k] = 1'b0;
        end
      end else if (rl[k] == 1) begin
        anc[k] = t; ranc[k] = t;
      end else if (!ldone[k] && t - anc[k] == LC) begin
        m_long[k] = 1'b1; ldone[k] = 1'b1; ranc[k] = t;
      end else if (REP && ldone[k] && t > ranc[k] && (t - ranc[k]) % RC == 0) begin
        m_press[k] = 1'b1;
      end
      m_lvl[k] = lvl[k];
    end
    sy2 = sy1;
    sy1 = kif.key_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("level",   kif.key_level,   m_lvl);
    chk("press",   kif.key_press,   m_press);
    chk("release", kif.key_release, m_rel);
    chk("long",    kif.key_long,    m_long);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    int dur [KW];
    kif.key_n = '1;
    step(3);
    chk("reset level", kif.key_level, 0);
    chk("reset pulses", {kif.key_press, kif.key_release, kif.key_long}, 0);
    rst_n = 1'b1;
    step(3);

    // Clean press on key 0: low for 8 samples.
    kif.key_n[0] = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #2;
      if (k == 7) kif.key_n[0] = 1'b1;
      @(negedge clk);
      chk("clean press", kif.key_press[0], k == 6);
      chk("clean level", kif.key_level[0], k >= 6 && k < 14);
      chk("clean release", kif.key_release[0], k == 14);
      chk("clean nolong", kif.key_long[0], 0);
      if (k == 6) chk("model press", m_press[0], 1);
    end
    step(5);

    // Bounce on key 1: low 3, high 1, then low.
    kif.key_n[1] = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk); #2;
      if (k == 2) kif.key_n[1] = 1'b1;
      if (k == 3) kif.key_n[1] = 1'b0;
      @(negedge clk);
      chk("bounce press", kif.key_press[1], k == 10);
      chk("bounce level", kif.key_level[1], k >= 10);
    end
    kif.key_n[1] = 1'b1;
    step(15);

    // Long press on key 2: held 20 samples.
    kif.key_n[2] = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk); #2;
      if (k == 19) kif.key_n[2] = 1'b1;
      @(negedge clk);
      chk("long press", kif.key_press[2], k == 6 || (REP && k == 19));
      chk("long pulse", kif.key_long[2], k == 16);
      chk("long release", kif.key_release[2], k == 26);
      chk("long level", kif.key_level[2], k >= 6 && k < 26);
      if (k == 16) chk("model long", m_long[2], 1);
    end
    step(5);

    // Keys 0 and 3 together, then reset mid-hold.
    kif.key_n[0] = 1'b0; kif.key_n[3] = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk); #2;
      @(negedge clk);
      chk("simul press", {kif.key_press[3], kif.key_press[0]}, (k == 6) ? 2'b11 : 2'b00);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst level", kif.key_level, 0);
    chk("rst pulses", {kif.key_press, kif.key_release, kif.key_long}, 0);
    step(2);
    rst_n = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #2;
      @(negedge clk);
      chk("re-press", {kif.key_press[3], kif.key_press[0]}, (k == 6) ? 2'b11 : 2'b00);
      chk("rst norelease", kif.key_release, 0);
    end
    kif.key_n = '1;
    step(15);

    // Auto-repeat window on key 1: held 25 samples.
    kif.key_n[1] = 1'b0;
    for (int k = 0; k <= 33; k++) begin
      @(posedge clk); #2;
      if (k == 24) kif.key_n[1] = 1'b1;
      @(negedge clk);
      chk("rep press", kif.key_press[1], k == 6 || (REP && (k == 19 || k == 22 || k == 25)));
      chk("rep long", kif.key_long[1], k == 16);
      chk("rep release", kif.key_release[1], k == 31);
    end
    step(5);

    // Release bounce on key 0: one low sample during release debounce.
    kif.key_n[0] = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk); #2;
      if (k == 11) kif.key_n[0] = 1'b1;
      if (k == 14) kif.key_n[0] = 1'b0;
      if (k == 15) kif.key_n[0] = 1'b1;
      @(negedge clk);
      chk("rb release", kif.key_release[0], k == 22);
      chk("rb level", kif.key_level[0], k >= 6 && k < 22);
      chk("rb nolong", kif.key_long[0], 0);
    end
    step(5);

    // Random phase: mixed short glitches and long holds, occasional reset.
    for (int k = 0; k < KW; k++) dur[k] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      rst_n = ($urandom_range(0, 599) != 0);
      for (int k = 0; k < KW; k++) begin
        dur[k]--;
        if (dur[k] <= 0) begin
          kif.key_n[k] = ~kif.key_n[k];
          dur[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D) : $urandom_range(1, 3 * LC);
        end
      end
    end
    rst_n = 1'b1;
    kif.key_n = '1;
    step(20);
    chk("final level", kif.key_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Debounces and synchronizes KEY_W active-low push buttons on the board.
- Produces a clean level per key, plus single-cycle press, release and long-press pulses.
- Sits between the board key pins and the LED/pattern control logic; the input-side counterpart to the LED drivers.
- One independent FSM and counter per key; no interaction between keys.

Parameters:
- KEY_W, 4, number of keys.
- DEBOUNCE_CYC, 1_000_000, stable cycles required to accept an edge (20 ms at 50 MHz); legal range >=1.
- LONG_CYC, 50_000_000, held cycles after the accepted press before key_long fires (1 s at 50 MHz); legal range >=1.
- REPEAT_CYC, 10_000_000, auto-repeat period; only used with KEY_REPEAT_EN; legal range >=1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- key_n  input  KEY_W  raw button pins, asynchronous, 0 = pressed.
- key_level  output  KEY_W  debounced state, 1 = pressed.
- key_press  output  KEY_W  1-cycle pulse on accepted press.
- key_release  output  KEY_W  1-cycle pulse on accepted release.
- key_long  output  KEY_W  1-cycle pulse when held for LONG_CYC.

Behaviour:
- Reset values:
  - Synchronizer flops all 1 (released).
  - All outputs 0.
  - All FSMs in IDLE; counters 0; long flags 0.
- Reset is effective mid-debounce or mid-hold; no pulse is emitted on reset exit.
- Synchronizer: 2-flop synchronizer per bit. Define s[i] = ~sync2[i].
- Counters: 32-bit, one per key. The counter never wraps; it is cleared on every state change.
- FSM transitions per key, evaluated each rising edge:
  - IDLE: if s=1, go to PRESS_DB and set cnt=0.
  - PRESS_DB:
    - If s=0, return to IDLE with no pulse.
    - Else if cnt==DEBOUNCE_CYC-1, go to PRESSED, pulse key_press, set key_level=1, set cnt=0.
    - Else cnt+1.
  - PRESSED:
    - If s=0, go to RELEASE_DB and set cnt=0.
    - Else if cnt==LONG_CYC-1, go to LONG, pulse key_long, set long flag=1.
    - Else cnt+1.
  - LONG: if s=0, go to RELEASE_DB and set cnt=0.
  - RELEASE_DB:
    - If s=1 (bounce), return to LONG if long flag=1, else return to PRESSED; set cnt=0. The long timer restarts, and no pulse is emitted.
    - Else if cnt==DEBOUNCE_CYC-1, go to IDLE, pulse key_release, set key_level=0, clear long flag.
    - Else cnt+1.
- Latency:
  - Let E0 be the first edge at which key_n is sampled low.
  - key_press is high for exactly the cycle following edge E0+2+DEBOUNCE_CYC.
  - Release latency is symmetric.
- Pulse rules:
  - All pulse outputs are registered and exactly one cycle wide.
  - key_press and key_release never assert in the same cycle for one key.
  - key_long fires at most once per press (absent the optional feature).
- Bounces: any glitch shorter than DEBOUNCE_CYC cycles (post-sync) during a debounce state produces no output change.
- Simultaneous keys: each key is fully independent, and several pulse bits may be high in the same cycle.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- When defined:
  - A per-key repeat counter runs while in LONG.
  - key_press re-pulses every REPEAT_CYC cycles, first pulse REPEAT_CYC cycles after the key_long cycle.
  - The repeat counter clears on leaving LONG, and restarts on a bounce return to LONG.
  - key_long itself still fires once.
- When undefined: no repeat logic; key_press fires only on the PRESSED entry.

Test Plan:
- Use DEBOUNCE_CYC=4, LONG_CYC=10, REPEAT_CYC=3, KEY_W=4 for all scenarios.
- Clean press: key_n[0] low at E0, held 8 cycles -> key_press[0] pulses in cycle after E0+6, key_level[0]=1 from then; no key_long.
- Bounce: key_n[1] low 3 cycles, high 1, low stable -> no key_press while bouncing; single key_press[1] 4 stable post-sync cycles after the final fall.
- Long press and release: hold key_n[2] 20 cycles then release clean -> key_press, key_long 10 cycles after key_press, key_release 6 cycles after release edge, key_level back to 0.
- Simultaneous keys plus reset: key_n[0] and key_n[3] pressed same cycle -> both press pulses same cycle. Then assert rst_n low mid-hold -> outputs 0 immediately, no release pulse; after reset release, still-held keys re-debounce and pulse key_press again.
- KEY_REPEAT_EN: hold key_n[1] 25 cycles -> key_long at press+10, then key_press pulses every 3 cycles until release begins.
- Release bounce: during RELEASE_DB, key_n returns low for 1 cycle -> no key_release; FSM returns to held state; key_level stays 1.
